pipelined_cla_addsub: RTL



---
 rtl/alu_pkg.sv | 10 +
 rtl/cla_block.sv | 53 +++++
 rtl/pipelined_cla_addsub.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: operation encoding and default operand/lookahead widths.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int WORD_WIDTH = 32;
  localparam int CLA_BLOCK  = 8;

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead unit: every internal carry is a flat
// sum-of-products of g/p terms and cin rather than a ripple chain.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb,
  output logic             G,
  output logic             P
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic             term;
  logic             grp_gen;

  assign g = a & b;
  assign p = a | b;

  // c[i] = (cin & p[0..i-1]) | OR_j (g[j] & p[j+1..i-1])
  always_comb begin
    c       = '0;
    term    = 1'b0;
    grp_gen = 1'b0;
    for (int i = 0; i <= BLOCK; i++) begin
      term = cin;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    for (int j = 0; j < BLOCK; j++) begin
      term = g[j];
      for (int k = j + 1; k < BLOCK; k++) term = term & p[k];
      grp_gen = grp_gen | term;
    end
  end

  assign sum   = a ^ b ^ c[BLOCK-1:0];
  assign cout  = c[BLOCK];
  assign c_msb = c[BLOCK-1];
  assign G     = grp_gen;
  assign P     = &p;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined adder/subtractor resolving one BLOCK-bit lookahead chunk per stage.
// Each stage's x register carries operand A with the finished chunks already replaced by sum bits.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int BLOCK = CLA_BLOCK
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = WIDTH / BLOCK;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic             vld_p [STAGES];
  logic [WIDTH-1:0] x_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic             c_p   [STAGES];
  logic             ovf_p;
  logic             zero_p;

  logic             vld_in     [STAGES];
  logic [WIDTH-1:0] x_in       [STAGES];
  logic [WIDTH-1:0] b_in       [STAGES];
  logic             c_in       [STAGES];
  logic [WIDTH-1:0] x_next     [STAGES];
  logic [BLOCK-1:0] chunk_sum  [STAGES];
  logic             chunk_cout [STAGES];
  logic             chunk_cmsb [STAGES];
  logic             unused_g   [STAGES];
  logic             unused_p   [STAGES];

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  assign b_eff = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign c0    = (in_sub == OP_SUB) ? 1'b1 : in_cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] MASK = WIDTH'({BLOCK{1'b1}}) << (k * BLOCK);

    if (k == 0) begin : g_first
      assign vld_in[k] = in_valid;
      assign x_in[k]   = in_a;
      assign b_in[k]   = b_eff;
      assign c_in[k]   = c0;
    end else begin : g_next
      assign vld_in[k] = vld_p[k-1];
      assign x_in[k]   = x_p[k-1];
      assign b_in[k]   = b_p[k-1];
      assign c_in[k]   = c_p[k-1];
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a     (x_in[k][k*BLOCK +: BLOCK]),
      .b     (b_in[k][k*BLOCK +: BLOCK]),
      .cin   (c_in[k]),
      .sum   (chunk_sum[k]),
      .cout  (chunk_cout[k]),
      .c_msb (chunk_cmsb[k]),
      .G     (unused_g[k]),
      .P     (unused_p[k])
    );

    assign x_next[k] = (x_in[k] & ~MASK) | (WIDTH'(chunk_sum[k]) << (k * BLOCK));
  end

  // Stage registers: the whole pipeline advances together unless the output is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= 1'b0;
        x_p[k]   <= '0;
        b_p[k]   <= '0;
        c_p[k]   <= 1'b0;
      end
      ovf_p  <= 1'b0;
      zero_p <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= vld_in[k];
        x_p[k]   <= x_next[k];
        b_p[k]   <= b_in[k];
        c_p[k]   <= chunk_cout[k];
      end
      ovf_p  <= chunk_cmsb[STAGES-1] ^ chunk_cout[STAGES-1];
      zero_p <= (x_next[STAGES-1] == '0);
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign out_sum   = x_p[STAGES-1];
  assign out_cout  = c_p[STAGES-1];
  assign out_ovf   = ovf_p;
  assign out_zero  = zero_p;

endmodule
